ricosoc_timer: RTL and testbench

Memory-mapped timer/compare peripheral on the SoC `iomem_*` bus, directly downstream of the SoC bus decode: it answers CPU accesses in its address window and drives one interrupt line back into the SoC's `irq_5`..`irq_7` inputs. It provides the following:
- a 16-bit prescaler
- a 32-bit up-counter
- a compare register
- a sticky match flag with interrupt enable
- periodic (auto-reload) mode

---
 rtl/ricosoc_timer.sv | 148 ++++++++++++++
 tb/tb_ricosoc_timer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ricosoc_timer.sv
// Memory-mapped timer/compare peripheral on the SoC iomem bus: 16-bit prescaler,
// 32-bit up-counter, compare register, sticky match flag, optional auto-reload.
module ricosoc_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_PRESCALE = 8'h04;
   localparam logic [7:0] OFF_COUNT    = 8'h08;
   localparam logic [7:0] OFF_COMPARE  = 8'h0C;
   localparam logic [7:0] OFF_STATUS   = 8'h10;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      end
      return res;
   endfunction

   logic [2:0]  ctrl_r;       // [0] en, [1] irq_en, [2] reload
   logic [15:0] prescale_r;
   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic        match_r;
   logic [15:0] presc_r;

   logic        sel_s;
   logic        wr_s;
   logic        wr_ctrl_s;
   logic        wr_prescale_s;
   logic        wr_count_s;
   logic        wr_compare_s;
   logic        wr_status_s;
   logic        tick_s;
   logic        hit_s;
   logic        clr_s;
   logic [15:0] prescale_wr_s;
   logic [31:0] count_wr_s;
   logic [31:0] compare_wr_s;
   logic [31:0] rd_data_s;

   // Bus decode, read mux and tick/match qualification from pre-edge state.
   always_comb begin
      sel_s         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !iomem_ready;
      wr_s          = sel_s && (iomem_wstrb != 4'b0000);
      wr_ctrl_s     = 1'b0;
      wr_prescale_s = 1'b0;
      wr_count_s    = 1'b0;
      wr_compare_s  = 1'b0;
      wr_status_s   = 1'b0;
      rd_data_s     = 32'h0000_0000;
      case (iomem_addr[7:0])
         OFF_CTRL: begin
            wr_ctrl_s = wr_s;
            rd_data_s = {29'h0000_0000, ctrl_r};
         end
         OFF_PRESCALE: begin
            wr_prescale_s = wr_s;
            rd_data_s     = {16'h0000, prescale_r};
         end
         OFF_COUNT: begin
            wr_count_s = wr_s;
            rd_data_s  = count_r;
         end
         OFF_COMPARE: begin
            wr_compare_s = wr_s;
            rd_data_s    = compare_r;
         end
         OFF_STATUS: begin
            wr_status_s = wr_s;
            rd_data_s   = {31'h0000_0000, match_r};
         end
         default: begin
            rd_data_s = 32'h0000_0000;
         end
      endcase
      prescale_wr_s = {iomem_wstrb[1] ? iomem_wdata[15:8] : prescale_r[15:8],
                       iomem_wstrb[0] ? iomem_wdata[7:0]  : prescale_r[7:0]};
      count_wr_s    = byte_merge(count_r, iomem_wdata, iomem_wstrb);
      compare_wr_s  = byte_merge(compare_r, iomem_wdata, iomem_wstrb);
      tick_s        = ctrl_r[0] && (presc_r == prescale_r);
      // A CPU write to COUNT suppresses both the increment and the compare.
      hit_s         = tick_s && !wr_count_s && (count_r == compare_r);
      clr_s         = wr_status_s && iomem_wstrb[0] && iomem_wdata[0];
   end

   // Register file, prescaler, counter and bus response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_r      <= 3'b000;
         prescale_r  <= 16'h0000;
         count_r     <= 32'h0000_0000;
         compare_r   <= 32'hFFFF_FFFF;
         match_r     <= 1'b0;
         presc_r     <= 16'h0000;
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'h0000_0000;
      end else begin
         iomem_ready <= sel_s;
         iomem_rdata <= sel_s ? rd_data_s : 32'h0000_0000;

         if (wr_ctrl_s && iomem_wstrb[0]) begin
            ctrl_r <= iomem_wdata[2:0];
         end
         if (wr_prescale_s) begin
            prescale_r <= prescale_wr_s;
         end
         if (wr_compare_s) begin
            compare_r <= compare_wr_s;
         end

         if (wr_prescale_s || !ctrl_r[0] || tick_s) begin
            presc_r <= 16'h0000;
         end else begin
            presc_r <= presc_r + 16'd1;
         end

         if (wr_count_s) begin
            count_r <= count_wr_s;
         end else if (tick_s) begin
            count_r <= (hit_s && ctrl_r[2]) ? 32'h0000_0000 : count_r + 32'd1;
         end

         // A new match beats a simultaneous write-1-to-clear.
         if (hit_s) begin
            match_r <= 1'b1;
         end else if (clr_s) begin
            match_r <= 1'b0;
         end
      end
   end

   assign irq = match_r & ctrl_r[1];

endmodule

// File: tb/tb_ricosoc_timer.sv
// Randomised scoreboard bench for ricosoc_timer against a time-based reference model.
module tb_ricosoc_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        irq;

   localparam logic [31:0] BASE = 32'h0300_0000;

   ricosoc_timer dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: architectural registers plus a prescaler phase epoch.
   logic [2:0]  m_ctrl;
   logic [15:0] m_pre;
   logic [31:0] m_count;
   logic [31:0] m_cmp;
   logic        m_match;
   logic        m_ready;
   longint      m_t = 0;
   longint      m_epoch = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   task automatic model_reset();
      m_ctrl  = 3'd0;
      m_pre   = 16'd0;
      m_count = 32'd0;
      m_cmp   = 32'hFFFF_FFFF;
      m_match = 1'b0;
      m_ready = 1'b0;
      m_epoch = m_t;
      exp_q.delete();
   endtask

   // One rising edge of the model, evaluated from the inputs present at that edge.
   task automatic model_step();
      logic        sel, wr, tick, hit, wr_cnt, new_epoch;
      logic [7:0]  off;
      logic [31:0] rdv, tmp;
      exp_t        e;
      m_t++;
      sel    = iomem_valid && (iomem_addr[31:8] == BASE[31:8]) && !m_ready;
      wr     = sel && (iomem_wstrb != 4'd0);
      off    = iomem_addr[7:0];
      wr_cnt = wr && (off == 8'h08);
      tick   = m_ctrl[0] && (((m_t - m_epoch) % (longint'(m_pre) + 64'sd1)) == 0);
      hit    = tick && !wr_cnt && (m_count == m_cmp);
      new_epoch = !m_ctrl[0] || (wr && off == 8'h04);
      if (sel) begin
         case (off)
            8'h00:   rdv = {29'd0, m_ctrl};
            8'h04:   rdv = {16'd0, m_pre};
            8'h08:   rdv = m_count;
            8'h0C:   rdv = m_cmp;
            8'h10:   rdv = {31'd0, m_match};
            default: rdv = 32'd0;
         endcase
         e.chk = (iomem_wstrb == 4'd0);
         e.val = rdv;
         exp_q.push_back(e);
      end
      m_ready = sel;
      if (tick && !wr_cnt) begin
         m_count = (hit && m_ctrl[2]) ? 32'd0 : m_count + 32'd1;
      end
      if (wr) begin
         case (off)
            8'h00: if (iomem_wstrb[0]) m_ctrl = iomem_wdata[2:0];
            8'h04: begin
               tmp   = bmerge({16'd0, m_pre}, iomem_wdata, iomem_wstrb);
               m_pre = tmp[15:0];
            end
            8'h08: m_count = bmerge(m_count, iomem_wdata, iomem_wstrb);
            8'h0C: m_cmp = bmerge(m_cmp, iomem_wdata, iomem_wstrb);
            8'h10: if (iomem_wstrb[0] && iomem_wdata[0]) m_match = 1'b0;
            default: ;
         endcase
      end
      if (hit) m_match = 1'b1;
      if (new_epoch) m_epoch = m_t;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!reset) model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         output logic [31:0] rd);
      logic acc;
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wstrb = be;
      iomem_wdata = d;
      acc = 1'b0;
      for (int i = 0; i < 3 && !acc; i++) begin
         cyc();
         acc = m_ready;
      end
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] rd;
      access(BASE + {24'd0, off}, 4'hF, d, rd);
   endtask

   // Monitor: compares every cycle and pops the scoreboard on each ready.
   initial begin
      forever begin
         @(negedge clk);
         check("ready", {31'd0, iomem_ready}, {31'd0, m_ready});
         check("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[1]});
         if (iomem_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ready: got ready=1 required no pending access at %0t", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.chk) check("rdata", iomem_rdata, e.val);
            end
         end else begin
            check("rdata_idle", iomem_rdata, 32'd0);
         end
      end
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] dflt [5];
      int          pulses;
      logic [7:0]  offs [7];
      dflt = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'hFC};
      reset = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'd0;
      iomem_addr  = 32'd0;
      iomem_wdata = 32'd0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Dirty state, then reset in the middle of an access.
      wr(8'h04, 32'd1);
      wr(8'h0C, 32'd2);
      wr(8'h00, 32'd7);
      idle(8);
      iomem_valid = 1'b1;
      iomem_addr  = BASE + 32'h8;
      iomem_wstrb = 4'd0;
      @(posedge clk);
      model_step();
      #2;
      reset = 1'b1;
      model_reset();
      iomem_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("irq_after_reset", {31'd0, irq}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         access(BASE + 32'(i * 4), 4'd0, 32'd0, rd);
         check("reset_default", rd, dflt[i]);
      end

      // Held valid: accepted every other cycle.
      iomem_valid = 1'b1;
      iomem_addr  = BASE + 32'h8;
      iomem_wstrb = 4'd0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         pulses += int'(iomem_ready);
      end
      iomem_valid = 1'b0;
      idle(1);
      check("held_valid_pulses", 32'(pulses), 32'd3);
      access(32'h0400_0000, 4'd0, 32'd0, rd);
      access(BASE + 32'h14, 4'd0, 32'd0, rd);
      check("offset_14", rd, 32'd0);

      // Free run, PRESCALE=3.
      wr(8'h04, 32'd3);
      wr(8'h00, 32'd1);
      idle(40);
      access(BASE + 32'h8, 4'd0, 32'd0, rd);
      n_cmp++;
      if (rd < 32'd9 || rd > 32'd11) begin
         n_err++;
         $display("FAIL count_40: got %0d required 10 +/- 1", rd);
      end
      access(BASE + 32'hC, 4'b0010, 32'h0000_AB00, rd);
      access(BASE + 32'hC, 4'd0, 32'd0, rd);
      check("compare_byte", rd, 32'hFFFF_ABFF);

      // Periodic mode with irq, then clears that collide with matches.
      wr(8'h00, 32'd0);
      wr(8'h08, 32'd0);
      wr(8'h0C, 32'd4);
      wr(8'h04, 32'd0);
      wr(8'h00, 32'd7);
      idle(12);
      access(BASE + 32'h10, 4'b0001, 32'd1, rd);
      idle(12);
      for (int i = 0; i < 12; i++) begin
         idle($urandom_range(0, 4));
         access(BASE + 32'h10, 4'b0001, 32'd1, rd);
      end
      wr(8'h08, 32'd100);
      access(BASE + 32'h8, 4'd0, 32'd0, rd);

      // Wrap through 0xFFFF_FFFF without reload.
      wr(8'h00, 32'd0);
      wr(8'h10, 32'd1);
      wr(8'h0C, 32'hFFFF_FFFF);
      wr(8'h08, 32'hFFFF_FFFE);
      wr(8'h04, 32'd3);
      wr(8'h00, 32'd3);
      idle(9);
      access(BASE + 32'h8, 4'd0, 32'd0, rd);
      access(BASE + 32'h10, 4'd0, 32'd0, rd);
      idle(3);
      access(BASE + 32'h8, 4'd0, 32'd0, rd);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         logic [7:0]  off;
         logic [31:0] a, d;
         logic [3:0]  be;
         off = offs[$urandom_range(0, 6)];
         a   = BASE + {24'd0, off};
         if ($urandom_range(0, 9) == 0) a = a + 32'h0000_0100;
         be  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         d   = $urandom;
         if (off == 8'h04) d = 32'($urandom_range(0, 5));
         if (off == 8'h08 || off == 8'h0C) d = 32'($urandom_range(0, 20));
         access(a, be, d, rd);
         idle($urandom_range(0, 3));
      end

      idle(3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
